inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch stage for the OpenMIPS core. It owns the program counter and drives the instruction ROM's address port. It buffers fetched words in a small queue and hands {pc, inst} pairs to the IF/ID register through a valid/ready handshake. It applies taken-branch redirects from ID with MIPS single-delay-slot semantics.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 2, fetch-queue entries (≥2).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  32  byte address; equals pc.
- rom_data  in  32  ROM word at rom_addr, combinational read (same cycle).
- out_valid  out  1  queue head valid.
- out_ready  in  1  IF/ID accepts the head this cycle.
- out_pc  out  32  head PC.
- out_inst  out  32  head instruction.
- br_valid  in  1  taken branch/jump resolved in ID this cycle.
- br_target  in  32  redirect address.
- flush, flush_pc  in  1/32  exception redirect; present only with IF_EXC_FLUSH_EN.

## Operation
- Reset (rst low): pc=RESET_PC, rom_ce=0, queue empty, out_valid=0, out_pc=0, out_inst=0.
- rom_ce goes 1 at the first rising edge after rst releases and stays 1. rom_addr=pc at all times.
- Fetch: a fetch occurs when rom_ce=1 and (count<DEPTH or pop this cycle). On a fetch, {pc, rom_data} is enqueued and pc<=pc+4. Otherwise pc holds.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 → 0.
- Pop: out_valid && out_ready. The head advances in FIFO order.
- Branch (br_valid=1): the branch itself has already left the queue. The delay slot is the next instruction in program order:
  - If the queue is non-empty, the head is the delay slot. Retain the head only (pop rules still apply to it), drop all other entries, and suppress this cycle's fetch.
  - If the queue is empty, enqueue this cycle's fetch as the delay slot.
  - In both cases, pc<=br_target & ~32'h3.
- br_valid arriving in the cycle right after a previous br_valid is legal and handled identically.
- No instruction is ever duplicated or lost except the entries dropped by a redirect.

## Timing
- Fetch-to-output latency is 1 cycle. A word fetched at edge N is visible on out_* after edge N.
- Throughput is 1 instruction/cycle with out_ready held at 1.
- The first valid output (pc=RESET_PC) appears 2 edges after reset release.
- Redirect: the first fetch at the target happens in the cycle after br_valid. The target appears on out_* one cycle later, after the delay slot.
- Backpressure: out_* stays stable while out_valid=1 and out_ready=0.
- Async reset asserted mid-stream clears everything immediately. Outputs take their reset values without waiting for a clock edge.

## Configuration
- IF_EXC_FLUSH_EN defined:
  - Adds the flush and flush_pc ports.
  - flush=1 empties the queue completely, with no delay slot kept, and suppresses the fetch that cycle.
  - It sets pc<=flush_pc & ~3.
  - It has priority over br_valid.
  - out_valid=0 on the cycle after flush.
- Undefined: the ports are absent and only branch redirects exist.

## Structure
- Shared defines/package holds:
  - InstAddrBus and InstBus widths.
  - RstEnable as the active-low level.
  - RESET_PC default.
  - ChipEnable/ChipDisable constants.
- One sub-module, fetch_fifo: a DEPTH-entry {pc, inst} queue with push, pop, and keep_head_flush/full_flush inputs, plus a count output.
- inst_fetch holds the pc register, fetch gating, and redirect logic.

## Test plan
- Reset: hold rst=0 for 10 cycles. Expect rom_ce=0, rom_addr=0, out_valid=0. After release, expect rom_addr=0 then 4, and first out_pc=0 with out_inst=ROM[0].
- Streaming: out_ready=1 for 8 cycles. Expect out_pc=0,4,8,…,0x1C on consecutive cycles with matching out_inst.
- Backpressure: drop out_ready for 3 cycles after out_pc=0x8 appears. Expect rom_addr to freeze once 2 entries are queued. On release, expect 0x8,0xC,0x10 with no gaps or repeats.
- Branch with non-empty queue: ID resolves the branch at 0x10 with br_target=0x40 while 0x14 and 0x18 are queued. Expect output 0x14 then 0x40; 0x18 is never presented.
- Branch with empty queue and misaligned target: stall the upstream so the queue is empty, then apply br_target=0x43. Expect the delay slot (branch_pc+4) to be output, then out_pc=0x40.
- With IF_EXC_FLUSH_EN: assert flush with flush_pc=0x180 together with br_valid. Expect the queue to empty, no delay slot, and the next out_pc=0x180. Build without the macro and confirm it elaborates with no flush ports.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset/chip-enable levels and fetch-queue entry type for the IF stage.
package inst_fetch_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstAddrBus-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/inst_fetch_fifo.sv
// DEPTH-entry {pc, inst} queue; entry 0 is always the head, pops shift toward it.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  input  logic                         keep_head_flush,
  input  logic                         full_flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem     [DEPTH];
  fetch_entry_t  shifted [DEPTH];
  logic [CW-1:0] base;

  // base: occupancy after pop and flushes, i.e. the slot a push lands in
  always_comb begin
    base = count - CW'(pop);
    if (full_flush)           base = '0;
    else if (keep_head_flush) base = (count != '0 && !pop) ? CW'(1) : '0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH-1; i++) shifted[i] = mem[i+1];
    shifted[DEPTH-1] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= base + CW'(push);
      for (int i = 0; i < DEPTH; i++) begin
        if (push && CW'(i) == base) mem[i] <= wdata;
        else if (pop)               mem[i] <= shifted[i];
      end
    end
  end

  assign head = mem[0];
endmodule

// File: rtl/inst_fetch.sv
// OpenMIPS fetch stage: pc, ROM addressing, fetch queue and delay-slot branch redirect.
// Optional exception flush ports are enabled with IF_EXC_FLUSH_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                     DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce,
  output logic [InstAddrBus-1:0] rom_addr,
  input  logic [InstBus-1:0]     rom_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [InstAddrBus-1:0] out_pc,
  output logic [InstBus-1:0]     out_inst,
`ifdef IF_EXC_FLUSH_EN
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
`endif
  input  logic                   br_valid,
  input  logic [InstAddrBus-1:0] br_target
);
  localparam int CW = $clog2(DEPTH+1);

  logic [InstAddrBus-1:0] pc;
  logic [CW-1:0]          count;
  fetch_entry_t           head;
  logic                   pop, fetch, do_flush, keep;
  logic [InstAddrBus-1:0] flush_tgt;

`ifdef IF_EXC_FLUSH_EN
  assign do_flush  = flush;
  assign flush_tgt = word_align(flush_pc);
`else
  assign do_flush  = 1'b0;
  assign flush_tgt = '0;
`endif

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A non-empty queue already holds the delay slot, so the fetch this cycle is wrong-path.
  assign keep      = br_valid && out_valid && !do_flush;
  assign fetch     = rom_ce && (count < CW'(DEPTH) || pop) && !do_flush && !keep;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      rom_ce <= ChipDisable;
      pc     <= RESET_PC;
    end else begin
      rom_ce <= ChipEnable;
      if (do_flush)      pc <= flush_tgt;
      else if (br_valid) pc <= word_align(br_target);
      else if (fetch)    pc <= pc + 32'd4;
    end
  end

  assign rom_addr = pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .push            (fetch),
    .wdata           ('{pc: pc, inst: rom_data}),
    .pop             (pop),
    .keep_head_flush (br_valid),
    .full_flush      (do_flush),
    .head            (head),
    .count           (count)
  );

  assign out_pc   = out_valid ? head.pc   : '0;
  assign out_inst = out_valid ? head.inst : '0;
endmodule
